ram_io_frame_loader: RTL and testbench

- Configuration sequencer for one fabric column, such as the RAM_IO terminal column.
- Accepts a word stream of bitstream data over a valid/ready handshake, with framing: sync word, header, then frame words.
- For each frame word, drives the column's shared FrameData bus, then pulses exactly one FrameStrobe line so the addressed frame latches capture it.
- Sits between the global config port (UART/bitbang) and the tile frame latches of that column.

---
 rtl/ram_io_cfg_pkg.sv | 35 +++
 rtl/frame_strobe_decoder.sv | 27 ++
 rtl/ram_io_frame_loader.sv | 148 ++++++++++++++
 tb/tb_ram_io_frame_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_io_cfg_pkg.sv
// ram_io_cfg_pkg
//   Shared definitions for the RAM_IO column configuration loader:
//   sequencer states, header opcodes, header field positions and the
//   default stream synchronisation word.
package ram_io_cfg_pkg;

  // Sequencer states. Only IDLE reports busy=0.
  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    SETUP,
    STROBE,
    ERROR
  } state_t;

  // Header opcodes.
  localparam logic [7:0] OP_WRITE = 8'h01;

  // Header word layout: [31:24] opcode, [23:16] start index, [15:0] count.
  localparam int HDR_OP_MSB    = 31;
  localparam int HDR_OP_LSB    = 24;
  localparam int HDR_START_MSB = 23;
  localparam int HDR_START_LSB = 16;
  localparam int HDR_COUNT_MSB = 15;
  localparam int HDR_COUNT_LSB = 0;

  // Field widths derived from the layout above.
  localparam int IDX_W = HDR_START_MSB - HDR_START_LSB + 1;
  localparam int CNT_W = HDR_COUNT_MSB - HDR_COUNT_LSB + 1;

  // Default stream synchronisation pattern.
  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// frame_strobe_decoder
//   Turns a frame index plus an enable into the one-hot FrameStrobe vector
//   of the column. The output is all-zero when disabled or when the index
//   does not address an existing frame (idx >= MAX_FRAMES).
// Ports:
//   idx    in  IDX_W       frame index to strobe
//   en     in  1           strobe enable
//   strobe out MAX_FRAMES  one-hot (or zero) strobe vector
module frame_strobe_decoder #(
  parameter int MAX_FRAMES = 20,
  parameter int IDX_W      = 8
) (
  input  logic [IDX_W-1:0]      idx,
  input  logic                  en,
  output logic [MAX_FRAMES-1:0] strobe
);

  // NOTE: every bit is assigned on every pass through the block, so no
  // latch can be inferred even though the loop has no else branch.
  always_comb begin
    strobe = '0;
    for (int i = 0; i < MAX_FRAMES; i++) begin
      strobe[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/ram_io_frame_loader.sv
// ram_io_frame_loader
//   Configuration sequencer for one fabric column. Consumes a valid/ready
//   word stream framed as SYNC_WORD, header, frame words. Each frame word is
//   placed on FrameData, left to settle for one cycle, then exactly one
//   FrameStrobe line is pulsed for one cycle so the addressed frame latch
//   captures it. At most one frame word is consumed every three cycles.
// Ports:
//   CLK          in   1           configuration clock, rising edge
//   reset        in   1           asynchronous, active-high reset
//   s_data       in   FRAME_BITS  incoming stream word
//   s_valid      in   1           s_data valid
//   s_ready      out  1           loader can accept a word this cycle
//   FrameData    out  FRAME_BITS  frame data bus to the column tiles
//   FrameStrobe  out  MAX_FRAMES  one-hot frame capture strobe
//   busy         out  1           sequencer is not idle
//   done         out  1           one-cycle pulse at the end of a burst
//   error        out  1           sticky bad-header flag
module ram_io_frame_loader
  import ram_io_cfg_pkg::*;
#(
  parameter int                    FRAME_BITS = 32,
  parameter int                    MAX_FRAMES = 20,
  parameter logic [FRAME_BITS-1:0] SYNC_WORD  = FRAME_BITS'(SYNC_WORD_DEFAULT)
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [FRAME_BITS-1:0] FrameData,
  output logic [MAX_FRAMES-1:0] FrameStrobe,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] rem;

  logic             accept;
  logic             is_sync;
  logic [7:0]       hdr_op;
  logic [IDX_W-1:0] hdr_start;
  logic [CNT_W-1:0] hdr_count;
  logic [CNT_W:0]   hdr_end;
  logic             hdr_range_ok;

  assign accept  = s_valid && s_ready;
  assign is_sync = (s_data == SYNC_WORD);

  assign hdr_op    = s_data[HDR_OP_MSB:HDR_OP_LSB];
  assign hdr_start = s_data[HDR_START_MSB:HDR_START_LSB];
  assign hdr_count = s_data[HDR_COUNT_MSB:HDR_COUNT_LSB];

  // One bit wider than the count so start+count cannot wrap past the limit.
  assign hdr_end      = {{(CNT_W + 1 - IDX_W){1'b0}}, hdr_start} + {1'b0, hdr_count};
  assign hdr_range_ok = (hdr_end <= (CNT_W + 1)'(MAX_FRAMES));

  assign busy = (state != IDLE);

  // Strobe is decoded straight from registered state, so an asynchronous
  // reset drops it immediately without waiting for a clock edge.
  frame_strobe_decoder #(
    .MAX_FRAMES (MAX_FRAMES),
    .IDX_W      (IDX_W)
  ) u_strobe_dec (
    .idx    (idx),
    .en     (state == STROBE),
    .strobe (FrameStrobe)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values and the block order does not matter.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      rem       <= '0;
      s_ready   <= 1'b0;
      FrameData <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // s_ready is registered: it describes the state being entered. Only
      // SETUP and STROBE refuse words, so those paths override it below.
      s_ready <= 1'b1;
      done    <= 1'b0;

      case (state)
        IDLE: begin
          if (accept && is_sync) state <= HEADER;
        end

        HEADER: begin
          if (accept) begin
            if (hdr_op == OP_WRITE && hdr_count == '0) begin
              done  <= 1'b1;
              error <= 1'b0;
              state <= IDLE;
            end else if (hdr_op == OP_WRITE && hdr_range_ok) begin
              idx   <= hdr_start;
              rem   <= hdr_count;
              error <= 1'b0;
              state <= DATA;
            end else begin
              error <= 1'b1;
              state <= ERROR;
            end
          end
        end

        // Any word here is frame data, including one equal to SYNC_WORD.
        DATA: begin
          if (accept) begin
            FrameData <= s_data;
            s_ready   <= 1'b0;
            state     <= SETUP;
          end
        end

        // One settle cycle so FrameData is stable before the strobe rises.
        SETUP: begin
          s_ready <= 1'b0;
          state   <= STROBE;
        end

        STROBE: begin
          idx <= idx + 1'b1;
          rem <= rem - 1'b1;
          if (rem == CNT_W'(1)) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= DATA;
          end
        end

        ERROR: begin
          if (accept && is_sync) state <= HEADER;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_io_frame_loader.sv
// tb_ram_io_frame_loader
//   Directed bench for ram_io_frame_loader: reset state, basic burst,
//   range overflow and recovery, bad opcode, zero count, back-pressure with
//   an in-burst sync pattern, reset mid-burst and pre-sync garbage.
module tb_ram_io_frame_loader;

  localparam int          FB   = 32;
  localparam int          MF   = 20;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic          CLK = 1'b0;
  logic          reset;
  logic [FB-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [FB-1:0] FrameData;
  logic [MF-1:0] FrameStrobe;
  logic          busy;
  logic          done;
  logic          error;

  int n_asserts = 0;
  int n_fail    = 0;

  // Strobe log filled by the monitor.
  int          strobe_idx_q[$];
  logic [31:0] strobe_data_q[$];
  int          done_cnt  = 0;
  int          viol_cnt  = 0;

  ram_io_frame_loader #(
    .FRAME_BITS (FB),
    .MAX_FRAMES (MF),
    .SYNC_WORD  (SYNC)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 CLK = ~CLK;

  // Mid-cycle monitor: logs each strobe with the data on the bus, counts
  // done pulses, and flags non-one-hot strobes or s_ready during a strobe.
  always @(negedge CLK) begin
    if (FrameStrobe != '0) begin
      if ((FrameStrobe & (FrameStrobe - 1'b1)) != '0) viol_cnt++;
      if (s_ready) viol_cnt++;
      for (int i = 0; i < MF; i++) begin
        if (FrameStrobe[i]) strobe_idx_q.push_back(i);
      end
      strobe_data_q.push_back(FrameData);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    strobe_idx_q.delete();
    strobe_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Offers one word and waits until it is taken. With gappy=1, s_valid is
  // toggled randomly while waiting. Returns #1 after the accepting edge.
  task automatic send_word(input logic [31:0] w, input bit gappy);
    bit got = 0;
    bit rdy;
    s_data = w;
    for (int c = 0; c < 40 && !got; c++) begin
      s_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLK);
      rdy = s_ready;
      @(posedge CLK);
      if (rdy && s_valid) got = 1;
      #1;
    end
    s_valid = 1'b0;
    n_asserts++;
    assert (got)
    else begin
      n_fail++;
      $error("FAIL accept_timeout: word %h not accepted within 40 cycles", w);
    end
  endtask

  initial begin
    logic [31:0] junk;

    reset   = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    tick(2);

    // Reset state.
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_framedata", FrameData, 0);
    check("rst_strobe", 32'(FrameStrobe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    reset = 1'b0;
    tick(1);
    check("ready_after_reset", 32'(s_ready), 1);

    // Basic burst: frames 0 and 1.
    clear_log();
    send_word(SYNC, 0);
    check("hdr_busy", 32'(busy), 1);
    send_word(32'h0100_0002, 0);
    send_word(32'hDEAD_BEEF, 0);
    check("setup_s_ready", 32'(s_ready), 0);
    check("setup_strobe", 32'(FrameStrobe), 0);
    tick(1);
    check("strobe0_live", 32'(FrameStrobe), 32'h1);
    check("strobe0_s_ready", 32'(s_ready), 0);
    send_word(32'h1234_5678, 0);
    tick(3);
    check("basic_nstrobe", strobe_idx_q.size(), 2);
    if (strobe_idx_q.size() == 2) begin
      check("basic_idx0", strobe_idx_q[0], 0);
      check("basic_dat0", strobe_data_q[0], 32'hDEAD_BEEF);
      check("basic_idx1", strobe_idx_q[1], 1);
      check("basic_dat1", strobe_data_q[1], 32'h1234_5678);
    end
    check("basic_done", done_cnt, 1);
    check("basic_busy", 32'(busy), 0);
    check("basic_error", 32'(error), 0);
    check("hold_in_idle", FrameData, 32'h1234_5678);

    // Range overflow 19+2 > 20, junk while in ERROR, then valid 19+1.
    clear_log();
    send_word(SYNC, 0);
    send_word(32'h0113_0002, 0);
    check("ovf_error", 32'(error), 1);
    check("ovf_busy", 32'(busy), 1);
    send_word(32'h0100_0001, 0);
    send_word(32'h1234_0000, 0);
    send_word(32'hFFFF_FFFF, 0);
    check("ovf_still_error", 32'(error), 1);
    send_word(SYNC, 0);
    send_word(32'h0113_0001, 0);
    check("ovf_recover_error", 32'(error), 0);
    send_word(32'hA5A5_5A5A, 0);
    tick(3);
    check("ovf_nstrobe", strobe_idx_q.size(), 1);
    if (strobe_idx_q.size() == 1) begin
      check("ovf_idx19", strobe_idx_q[0], 19);
      check("ovf_dat19", strobe_data_q[0], 32'hA5A5_5A5A);
    end
    check("ovf_done", done_cnt, 1);

    // Bad opcode, then zero-count write straight from ERROR.
    clear_log();
    send_word(SYNC, 0);
    send_word(32'h0700_0001, 0);
    check("badop_error", 32'(error), 1);
    send_word(SYNC, 0);
    send_word(32'h0105_0000, 0);
    check("zero_done_pulse", 32'(done), 1);
    check("zero_error", 32'(error), 0);
    check("zero_busy", 32'(busy), 0);
    tick(2);
    check("zero_done_once", done_cnt, 1);
    check("badop_zero_nstrobe", strobe_idx_q.size(), 0);

    // Back-pressure with random s_valid gaps; middle word equals SYNC.
    clear_log();
    send_word(SYNC, 1);
    send_word(32'h0103_0003, 1);
    send_word(32'hC0DE_0003, 1);
    send_word(SYNC, 1);
    send_word(32'hC0DE_0005, 1);
    tick(4);
    check("bp_nstrobe", strobe_idx_q.size(), 3);
    if (strobe_idx_q.size() == 3) begin
      check("bp_idx3", strobe_idx_q[0], 3);
      check("bp_dat3", strobe_data_q[0], 32'hC0DE_0003);
      check("bp_idx4", strobe_idx_q[1], 4);
      check("bp_dat4", strobe_data_q[1], SYNC);
      check("bp_idx5", strobe_idx_q[2], 5);
      check("bp_dat5", strobe_data_q[2], 32'hC0DE_0005);
    end
    check("bp_done", done_cnt, 1);
    check("bp_busy", 32'(busy), 0);

    // Reset during the strobe of frame 1 of a 4-frame burst.
    clear_log();
    send_word(SYNC, 0);
    send_word(32'h0100_0004, 0);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    tick(1);
    check("mid_strobe1_live", 32'(FrameStrobe), 32'h2);
    reset = 1'b1;
    #1;
    check("mid_rst_strobe", 32'(FrameStrobe), 0);
    check("mid_rst_framedata", FrameData, 0);
    check("mid_rst_s_ready", 32'(s_ready), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_error", 32'(error), 0);
    check("mid_nstrobe_before", strobe_idx_q.size(), 1);
    tick(1);
    reset = 1'b0;
    clear_log();
    send_word(SYNC, 0);
    send_word(32'h0108_0001, 0);
    send_word(32'h0BAD_F00D, 0);
    tick(3);
    check("post_rst_nstrobe", strobe_idx_q.size(), 1);
    if (strobe_idx_q.size() == 1) begin
      check("post_rst_idx8", strobe_idx_q[0], 8);
      check("post_rst_dat8", strobe_data_q[0], 32'h0BAD_F00D);
    end
    check("post_rst_done", done_cnt, 1);

    // Pre-sync garbage in IDLE.
    clear_log();
    for (int k = 0; k < 10; k++) begin
      junk = $urandom;
      if (junk == SYNC) junk = junk ^ 32'h1;
      send_word(junk, 0);
      check("garbage_busy", 32'(busy), 0);
    end
    tick(2);
    check("garbage_nstrobe", strobe_idx_q.size(), 0);
    check("garbage_done", done_cnt, 0);
    check("garbage_error", 32'(error), 0);
    check("garbage_hold", FrameData, 32'h0BAD_F00D);

    check("strobe_violations", viol_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
